// File: rtl/alu_pkg.sv
// Shared constants for the ALU control block: ALU codes, funct codes,
// ALUop low-bit encodings, sequencer states and the mul/div op encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // Low two ALUop bits; the MSB selects R-type decoding from funct.
  localparam logic [1:0] AOP_ADD  = 2'b00;
  localparam logic [1:0] AOP_SUB  = 2'b01;
  localparam logic [1:0] AOP_OR   = 2'b10;
  localparam logic [1:0] AOP_SUB3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MD_RUN  = 2'b01,
    ST_MD_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

endpackage

// File: rtl/alu_funct_dec.sv
// Combinational ALUop/funct decoder: 4-bit ALU code, mul/div flag and
// unknown-R-type flag.
module alu_funct_dec
  import alu_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [5:0]         funct,
  output logic [3:0]         code,
  output logic               is_md,
  output logic               is_illegal
);

  // Decode the operation class, falling back to ADD for anything unknown
  always_comb begin
    code       = ALU_ADD;
    is_md      = 1'b0;
    is_illegal = 1'b0;
    if (alu_op[ALUOP_W-1]) begin
      case (funct)
        FN_ADD, FN_ADDU:                     code = ALU_ADD;
        FN_SUB, FN_SUBU:                     code = ALU_SUB;
        FN_AND:                              code = ALU_AND;
        FN_OR:                               code = ALU_OR;
        FN_XOR:                              code = ALU_XOR;
        FN_NOR:                              code = ALU_NOR;
        FN_SLT:                              code = ALU_SLT;
        FN_SLTU:                             code = ALU_SLTU;
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:  is_md = 1'b1;
        default: begin
          code       = ALU_ADD;
          is_illegal = 1'b1;
        end
      endcase
    end else begin
      case (alu_op[1:0])
        AOP_ADD:           code = ALU_ADD;
        AOP_SUB, AOP_SUB3: code = ALU_SUB;
        AOP_OR:            code = ALU_OR;
        default:           code = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control with registered decode and multi-cycle mul/div sequencing.
// Optional unknown-funct trap enabled by defining ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_control_seq
  import alu_pkg::*;
#(
  parameter int CTR_W     = 4,
  parameter int MD_CYCLES = 32,
  parameter int ALUOP_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [5:0]         funct,
  output logic [CTR_W-1:0]   alu_ctr,
  output logic               ctr_valid,
  output logic               stall,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic               md_done,
  output logic               hilo_we,
  output logic               illegal
);

  localparam int              CNT_W    = $clog2(MD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

  logic [3:0]       dec_code_s;
  logic             dec_md_s;
  logic             dec_ill_s;
  logic             trap_s;
  logic             accept_s;
  logic             start_s;
  logic             issue_s;
  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;

  alu_funct_dec #(.ALUOP_W(ALUOP_W)) u_dec (
    .alu_op     (alu_op),
    .funct      (funct),
    .code       (dec_code_s),
    .is_md      (dec_md_s),
    .is_illegal (dec_ill_s)
  );

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign trap_s = dec_ill_s;
`else
  assign trap_s = dec_ill_s & 1'b0;
`endif

  // Instructions are only taken in IDLE; MD_RUN and MD_DONE ignore valid_in.
  assign accept_s = valid_in && (state_r == ST_IDLE);
  assign start_s  = accept_s && dec_md_s;
  assign issue_s  = accept_s && !dec_md_s;

  // Next-state logic for the mul/div sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_MD_RUN;
        else         state_s = ST_IDLE;
      end
      ST_MD_RUN: begin
        if (cnt_r == '0) state_s = ST_MD_DONE;
        else             state_s = ST_MD_RUN;
      end
      ST_MD_DONE: state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // State register and run counter (loaded only when a mul/div starts)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      if (start_s)
        cnt_r <= CNT_LOAD;
      else if ((state_r == ST_MD_RUN) && (cnt_r != '0))
        cnt_r <= cnt_r - CNT_W'(1);
      else
        cnt_r <= cnt_r;
    end
  end

  // Registered outputs; done/hilo_we lag the MD_DONE state by one cycle so
  // stall covers MD_CYCLES+1 cycles and falls together with md_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctr   <= '0;
      ctr_valid <= 1'b0;
      stall     <= 1'b0;
      md_start  <= 1'b0;
      md_op     <= 2'b00;
      md_done   <= 1'b0;
      hilo_we   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      ctr_valid <= issue_s;
      illegal   <= issue_s && trap_s;
      if (issue_s && !trap_s)
        alu_ctr <= CTR_W'(dec_code_s);
      md_start  <= start_s;
      if (start_s)
        md_op <= funct[1:0];
      stall     <= (state_s != ST_IDLE);
      md_done   <= (state_r == ST_MD_DONE);
      hilo_we   <= (state_r == ST_MD_DONE);
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: decode sweep, mul/div sequencing,
// back-to-back hold, asynchronous reset and unknown-funct handling.
module tb_alu_control_seq;

  localparam int CTR_W = 4;
  localparam int MD    = 32;
  localparam int AW    = 3;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             valid_in = 1'b0;
  logic [AW-1:0]    alu_op = '0;
  logic [5:0]       funct = '0;
  logic [CTR_W-1:0] alu_ctr;
  logic             ctr_valid, stall, md_start, md_done, hilo_we, illegal;
  logic [1:0]       md_op;

  typedef struct packed {
    logic [CTR_W-1:0] ctr;
    logic             ill;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             e;
  logic [CTR_W-1:0] model_ctr = '0;
  int               vectors = 0;
  int               miscompares = 0;
  int               md_done_seen = 0;

  logic [5:0]       sweep_fn  [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                      6'b100110, 6'b100111, 6'b101010, 6'b101011};
  logic [3:0]       sweep_ctr [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                                      4'b0011, 4'b0100, 4'b0111, 4'b1000};
  logic [2:0]       op_in     [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
  logic [3:0]       op_ctr    [4] = '{4'b0010, 4'b0110, 4'b0110, 4'b0001};

  alu_control_seq #(.CTR_W(CTR_W), .MD_CYCLES(MD), .ALUOP_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .alu_op    (alu_op),
    .funct     (funct),
    .alu_ctr   (alu_ctr),
    .ctr_valid (ctr_valid),
    .stall     (stall),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_done   (md_done),
    .hilo_we   (hilo_we),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard on every ctr_valid
  always @(negedge clk) begin
    if (md_done === 1'b1) md_done_seen++;
    if (md_done === 1'b1 || hilo_we === 1'b1) begin
      vectors++;
      if (hilo_we !== md_done) begin
        miscompares++;
        $display("FAIL hilo_align: hilo_we=%b md_done=%b", hilo_we, md_done);
      end
    end
    if (ctr_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_ctr_valid: alu_ctr=%b with no instruction pending", alu_ctr);
      end else begin
        e = exp_q.pop_front();
        if (alu_ctr !== e.ctr || illegal !== e.ill) begin
          miscompares++;
          $display("FAIL decode: alu_ctr=%b illegal=%b expected alu_ctr=%b illegal=%b",
                   alu_ctr, illegal, e.ctr, e.ill);
        end
      end
    end else if (illegal !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL illegal_unaligned: illegal=%b ctr_valid=%b expected illegal=0", illegal, ctr_valid);
    end
  end

  // Issue one non-md instruction at a negedge; expectation goes on the queue
  task automatic send(input logic [2:0] op, input logic [5:0] fn,
                      input logic [3:0] exp_code, input logic exp_ill);
    valid_in = 1'b1;
    alu_op   = op;
    funct    = fn;
    exp_q.push_back({CTR_W'(exp_code), exp_ill});
    model_ctr = CTR_W'(exp_code);
    @(negedge clk);
    valid_in = 1'b0;
    vectors++;
    if (ctr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency: op=%b funct=%b ctr_valid=%b expected 1", op, fn, ctr_valid);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({alu_ctr, ctr_valid, stall, md_start, md_op, md_done, hilo_we, illegal} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: outputs=%b expected all 0",
               {alu_ctr, ctr_valid, stall, md_start, md_op, md_done, hilo_we, illegal});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({ctr_valid, md_start, md_done, stall} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_release: cv/start/done/stall=%b expected 0000",
                 {ctr_valid, md_start, md_done, stall});
      end
    end
  endtask

  task automatic test_decode_sweep();
    for (int i = 0; i < 8; i++) send(3'b100, sweep_fn[i], sweep_ctr[i], 1'b0);
    for (int i = 0; i < 4; i++) send(op_in[i], 6'b011000, op_ctr[i], 1'b0);
    vectors++;
    if (md_start !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL non_rtype_md: md_start=%b stall=%b expected 0 0", md_start, stall);
    end
    @(negedge clk);
    vectors++;
    if (ctr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pulse: ctr_valid=%b expected 0", ctr_valid);
    end
  endtask

  task automatic test_md(input logic [5:0] fn, input logic [1:0] exp_op);
    int stall_cycles;
    int done_cycle;
    logic [CTR_W-1:0] held;
    held = model_ctr;
    stall_cycles = 0;
    done_cycle = 0;
    valid_in = 1'b1;
    alu_op = 3'b100;
    funct = fn;
    @(negedge clk);
    valid_in = 1'b0;
    vectors++;
    if (md_start !== 1'b1 || md_op !== exp_op || ctr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL md_start: start=%b op=%b cv=%b expected 1 %b 0", md_start, md_op, ctr_valid, exp_op);
    end
    if (stall === 1'b1) stall_cycles++;
    for (int k = 2; k <= MD + 3; k++) begin
      @(negedge clk);
      if (stall === 1'b1) stall_cycles++;
      if (md_done === 1'b1 && done_cycle == 0) done_cycle = k;
      if (md_start !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL md_start_pulse: md_start=%b at cycle %0d expected 0", md_start, k);
      end
    end
    vectors++;
    if (done_cycle != MD + 2 || stall_cycles != MD + 1) begin
      miscompares++;
      $display("FAIL md_timing: done_cycle=%0d stall_cycles=%0d expected %0d %0d",
               done_cycle, stall_cycles, MD + 2, MD + 1);
    end
    vectors++;
    if (alu_ctr !== held || md_op !== exp_op) begin
      miscompares++;
      $display("FAIL md_hold: alu_ctr=%b md_op=%b expected %b %b", alu_ctr, md_op, held, exp_op);
    end
  endtask

  task automatic test_back_to_back();
    int first_cv;
    int first_done;
    int cv_cnt;
    first_cv = 0;
    first_done = 0;
    cv_cnt = 0;
    valid_in = 1'b1;
    alu_op = 3'b100;
    funct = 6'b011011;
    @(negedge clk);
    vectors++;
    if (md_start !== 1'b1 || md_op !== 2'b11) begin
      miscompares++;
      $display("FAIL divu_start: md_start=%b md_op=%b expected 1 11", md_start, md_op);
    end
    funct = 6'b100000;
    exp_q.push_back({CTR_W'(4'b0010), 1'b0});
    model_ctr = CTR_W'(4'b0010);
    for (int k = 2; k <= MD + 12; k++) begin
      @(negedge clk);
      if (md_done === 1'b1 && first_done == 0) first_done = k;
      if (ctr_valid === 1'b1) begin
        cv_cnt++;
        if (first_cv == 0) first_cv = k;
        valid_in = 1'b0;
      end
    end
    valid_in = 1'b0;
    vectors++;
    if (first_done != MD + 2 || first_cv != MD + 3 || cv_cnt != 1) begin
      miscompares++;
      $display("FAIL back_to_back: done=%0d cv=%0d count=%0d expected %0d %0d 1",
               first_done, first_cv, cv_cnt, MD + 2, MD + 3);
    end
  endtask

  task automatic test_reset_midrun();
    int done_before;
    valid_in = 1'b1;
    alu_op = 3'b100;
    funct = 6'b011011;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (21) @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_setup: stall=%b expected 1", stall);
    end
    done_before = md_done_seen;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({alu_ctr, ctr_valid, stall, md_start, md_op, md_done, hilo_we, illegal} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: outputs=%b expected all 0",
               {alu_ctr, ctr_valid, stall, md_start, md_op, md_done, hilo_we, illegal});
    end
    model_ctr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (MD + 10) @(negedge clk);
    vectors++;
    if (md_done_seen != done_before || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_abort: md_done pulses=%0d stall=%b expected 0 0",
               md_done_seen - done_before, stall);
    end
    send(3'b100, 6'b100010, 4'b0110, 1'b0);
  endtask

  task automatic test_illegal();
    logic [3:0] exp_code;
    send(3'b100, 6'b101010, 4'b0111, 1'b0);
    exp_code = TRAP ? 4'b0111 : 4'b0010;
    send(3'b100, 6'b111111, exp_code, TRAP);
    @(negedge clk);
    vectors++;
    if (alu_ctr !== CTR_W'(exp_code) || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_after: alu_ctr=%b illegal=%b expected %b 0", alu_ctr, illegal, exp_code);
    end
  endtask

  initial begin
    test_reset();
    test_decode_sweep();
    test_md(6'b011000, 2'b00);
    test_md(6'b011010, 2'b10);
    test_back_to_back();
    test_reset_midrun();
    test_illegal();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Next-generation ALU control for the CPU datapath.
- Decodes the main-control ALUop plus the full 6-bit funct into a parametrised-width ALU control code, registered one cycle.
- Adds sequencing for multi-cycle multiply/divide funct codes: a busy/stall handshake towards the main control and a start/done handshake towards the iterative mul/div unit.
- Sits between the main control/instruction register and the ALU / mul-div unit.

Parameters:
- CTR_W, 4, width of alu_ctr output (min 4)
- MD_CYCLES, 32, cycles the mul/div unit needs from md_start to result (>=2)
- ALUOP_W, 3, width of alu_op input

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  alu_op/funct valid this cycle
- alu_op  input  ALUOP_W  main-control ALU operation class
- funct  input  6  instruction funct field
- alu_ctr  output  CTR_W  registered ALU control code
- ctr_valid  output  1  alu_ctr valid (one cycle per accepted non-md instr)
- stall  output  1  high while a mul/div is in progress; upstream must hold inputs
- md_start  output  1  one-cycle pulse starting the mul/div unit
- md_op  output  2  00 mult, 01 multu, 10 div, 11 divu; held during run
- md_done  output  1  one-cycle pulse, result ready
- hilo_we  output  1  HI/LO write enable, coincident with md_done
- illegal  output  1  unknown R-type funct (only with optional feature)

Behaviour:
- Reset is asynchronous, active-low, and takes effect immediately. All outputs go to 0: alu_ctr=0, ctr_valid=0, stall=0, md_start=0, md_op=00, md_done=0, hilo_we=0, illegal=0. The FSM goes to IDLE and the counter to 0. Reset mid-run aborts the operation; no md_done is produced.
- ALU codes, zero-extended to CTR_W: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SUB 0110, SLT 0111, SLTU 1000.
- alu_op decode (ALUOP_W=3):
  - 000 → ADD
  - x01 with MSB 0 (001, 011) → SUB
  - 010 → OR
  - 1xx → R-type, decoded from funct
- R-type funct decode:
  - 100000/100001 → ADD
  - 100010/100011 → SUB
  - 100100 → AND
  - 100101 → OR
  - 100110 → XOR
  - 100111 → NOR
  - 101010 → SLT
  - 101011 → SLTU
  - 011000..011011 → mul/div
  - any other funct → ADD (default, never latch-inferred)
- Latency: one cycle. Inputs sampled at edge N appear on alu_ctr/ctr_valid after edge N; ctr_valid is high for one cycle.
- FSM states: IDLE, MD_RUN, MD_DONE.
  - IDLE with valid_in and a non-md op: update alu_ctr, pulse ctr_valid, stay in IDLE.
  - IDLE with valid_in and an md funct:
    - md_start=1 for one cycle; md_op latched from funct[1:0]; stall=1; counter=MD_CYCLES-1.
    - alu_ctr and ctr_valid are unchanged.
    - Go to MD_RUN.
  - MD_RUN: stall=1 and valid_in is ignored. Counter decrements each cycle; at 0, go to MD_DONE.
  - MD_DONE: md_done=1 and hilo_we=1 for one cycle; stall=0. Return to IDLE.
  - md_done follows md_start by exactly MD_CYCLES+1 cycles.
- Simultaneous events: valid_in during MD_DONE is not accepted. Upstream sees stall falling and presents the next instruction in the IDLE cycle.
- alu_op not 1xx: funct is ignored, so no mul/div start even if funct matches.
- Counter width is $clog2(MD_CYCLES); no wrap. The counter is reloaded only on entry to MD_RUN.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_TRAP_EN
- Defined:
  - Unknown R-type funct pulses illegal for one cycle, aligned with ctr_valid.
  - alu_ctr holds its previous value.
- Undefined:
  - illegal is tied to 0.
  - Unknown funct decodes to ADD, as today.

Decomposition:
- Shared package alu_pkg holds:
  - ALU code localparams (ALU_AND..ALU_SLTU)
  - funct constants (FN_ADD..FN_DIVU)
  - ALUop constants
  - FSM state typedef
  - md_op encoding
- Sub-module alu_funct_dec: purely combinational funct/ALUop decoder producing code, is_md and is_illegal. The sequencing FSM, counter and registers stay in alu_control_seq.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-cycle → all outputs 0 immediately; release, no spurious pulses.
- Decode sweep: alu_op=100 with funct 100000,100010,100100,100101,100110,100111,101010,101011 → alu_ctr 0010,0110,0000,0001,0011,0100,0111,1000 one cycle later; ctr_valid pulses each time. Also alu_op 000/001/011/010 → 0010/0110/0110/0001.
- Multiply: alu_op=100, funct=011000, MD_CYCLES=32 → md_start at cycle 1, md_op=00, stall high 33 cycles, md_done and hilo_we at cycle 34, alu_ctr unchanged.
- Back-to-back: divu followed by add held during stall → add accepted only after md_done, ctr_valid once, alu_ctr=0010.
- Reset mid-run: rst_n low at counter=10 → FSM IDLE, stall=0, md_done never asserted.
- Illegal funct 111111 with alu_op=100: with ALU_CTRL_ILLEGAL_TRAP_EN → illegal pulse, alu_ctr held; without → alu_ctr=0010, illegal=0.
